cache_control_nway: RTL and testbench

Parametrised N-way successor to the 2-way cache controller. It sequences hit, write-back, allocate and replacement-update for an N-way set-associative write-back, write-allocate cache. Replacement uses tree pseudo-LRU, and an invalid way is always preferred over the pseudo-LRU choice. The block sits between the CPU memory port and the arbiter, driving per-way array write enables and datapath mux selects, and it keeps saturating hit/miss counters.

---
 rtl/cache_control_nway.sv | 201 ++++++++++++++++++++
 tb/tb_cache_control_nway.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// cache_control_nway: N-way set-associative write-back/write-allocate cache
// controller with tree pseudo-LRU replacement and saturating hit/miss counters.
module cache_control_nway #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned WSEL  = $clog2(WAYS),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAYS-2:0]  plru_in,
    input  logic             arb_mem_resp,
    output logic [WAYS-1:0]  valid_w,
    output logic [WAYS-1:0]  tag_w,
    output logic [WAYS-1:0]  data_w,
    output logic [WAYS-1:0]  dirty_w,
    output logic             dirty_in,
    output logic             plru_w,
    output logic [WAYS-2:0]  plru_out,
    output logic [WSEL-1:0]  way_sel,
    output logic             dawmux_sel,
    output logic             addr_sel,
    output logic             arb_mem_read,
    output logic             arb_mem_write,
    output logic             mem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int unsigned TW = WAYS - 1;

    typedef enum logic [1:0] {TAG_COMP, WRITE_BACK, ALLOCATE, UPDATE} state_e;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [WSEL-1:0] lowest_set(input logic [WAYS-1:0] vec);
        logic [WAYS-1:0] sh;
        logic [WSEL-1:0] idx;
        idx = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            sh = vec >> i;
            if (sh[0]) idx = WSEL'(i);
        end
        return idx;
    endfunction

    // Walk the tree from the root; each bit picks the half holding the victim.
    function automatic logic [WSEL-1:0] plru_victim(input logic [TW-1:0] tree);
        logic [TW-1:0]   sh;
        logic [WSEL-1:0] way;
        int unsigned     node;
        way  = '0;
        node = 0;
        for (int unsigned lvl = 0; lvl < WSEL; lvl++) begin
            sh   = tree >> node;
            way  = WSEL'({way, sh[0]});
            node = 2 * node + 1 + 32'(sh[0]);
        end
        return way;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] tree,
                                                 input logic [WSEL-1:0] way);
        logic [TW-1:0]   t;
        logic [TW-1:0]   mask;
        logic [WSEL-1:0] sh;
        int unsigned     node;
        t    = tree;
        node = 0;
        for (int unsigned lvl = 0; lvl < WSEL; lvl++) begin
            sh   = way >> (WSEL - 1 - lvl);
            mask = TW'(1) << node;
            t    = sh[0] ? (t & ~mask) : (t | mask);
            node = 2 * node + 1 + 32'(sh[0]);
        end
        return t;
    endfunction

    state_e           state_q, state_d;
    logic [WSEL-1:0]  vr_q, vr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             req;
    logic [WSEL-1:0]  hw;
    logic [WSEL-1:0]  victim;
    logic [WAYS-1:0]  hw_oh;
    logic [WAYS-1:0]  vr_oh;
    logic [WAYS-1:0]  vic_valid_sh;
    logic [WAYS-1:0]  vic_dirty_sh;

    // Hit way, victim choice (invalid way preferred) and one-hot enables.
    assign req          = mem_read | mem_write;
    assign hw           = lowest_set(hit_vec);
    assign victim       = (&valid_vec) ? plru_victim(plru_in) : lowest_set(~valid_vec);
    assign hw_oh        = WAYS'(1) << hw;
    assign vr_oh        = WAYS'(1) << vr_q;
    assign vic_valid_sh = valid_vec >> victim;
    assign vic_dirty_sh = dirty_vec >> victim;
    assign hit_count    = rst ? '0 : hit_cnt_q;
    assign miss_count   = rst ? '0 : miss_cnt_q;

    // State, victim and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TAG_COMP;
            vr_q       <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vr_q       <= vr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state and control outputs; everything is forced low while in reset.
    always_comb begin
        state_d       = state_q;
        vr_d          = vr_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        valid_w       = '0;
        tag_w         = '0;
        data_w        = '0;
        dirty_w       = '0;
        dirty_in      = 1'b0;
        plru_w        = 1'b0;
        plru_out      = '0;
        way_sel       = '0;
        dawmux_sel    = 1'b0;
        addr_sel      = 1'b0;
        arb_mem_read  = 1'b0;
        arb_mem_write = 1'b0;
        mem_resp      = 1'b0;

        case (state_q)
            TAG_COMP: begin
                if (req) begin
                    if (|hit_vec) begin
                        mem_resp = 1'b1;
                        way_sel  = hw;
                        plru_w   = 1'b1;
                        plru_out = plru_touch(plru_in, hw);
                        if (mem_write) begin
                            data_w   = hw_oh;
                            dirty_w  = hw_oh;
                            dirty_in = 1'b1;
                        end
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        vr_d = victim;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        state_d = (vic_valid_sh[0] & vic_dirty_sh[0]) ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                arb_mem_write = 1'b1;
                way_sel       = vr_q;
                addr_sel      = 1'b1;
                if (arb_mem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                arb_mem_read = 1'b1;
                dawmux_sel   = 1'b1;
                data_w       = vr_oh;
                tag_w        = vr_oh;
                valid_w      = vr_oh;
                dirty_w      = vr_oh;
                if (arb_mem_resp) state_d = UPDATE;
            end
            UPDATE: begin
                plru_w   = 1'b1;
                plru_out = plru_touch(plru_in, vr_q);
                state_d  = TAG_COMP;
            end
            default: state_d = TAG_COMP;
        endcase

        if (rst) begin
            valid_w       = '0;
            tag_w         = '0;
            data_w        = '0;
            dirty_w       = '0;
            dirty_in      = 1'b0;
            plru_w        = 1'b0;
            plru_out      = '0;
            way_sel       = '0;
            dawmux_sel    = 1'b0;
            addr_sel      = 1'b0;
            arb_mem_read  = 1'b0;
            arb_mem_write = 1'b0;
            mem_resp      = 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: directed vector table, multi-cycle miss/reset
// sequences, counter saturation and a randomized run against a reference model.
module tb_cache_control_nway;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_read, mem_write, arb_mem_resp;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_in;

    logic [3:0]  valid_w, tag_w, data_w, dirty_w;
    logic        dirty_in, plru_w, dawmux_sel, addr_sel, arb_mem_read, arb_mem_write, mem_resp;
    logic [2:0]  plru_out;
    logic [1:0]  way_sel;
    logic [15:0] hit_count, miss_count;

    logic [3:0]  s_valid_w, s_tag_w, s_data_w, s_dirty_w;
    logic        s_dirty_in, s_plru_w, s_dawmux_sel, s_addr_sel, s_arb_mem_read, s_arb_mem_write, s_mem_resp;
    logic [2:0]  s_plru_out;
    logic [1:0]  s_way_sel;
    logic [3:0]  s_hit_count, s_miss_count;

    cache_control_nway #(.WAYS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
        .arb_mem_resp(arb_mem_resp),
        .valid_w(valid_w), .tag_w(tag_w), .data_w(data_w), .dirty_w(dirty_w),
        .dirty_in(dirty_in), .plru_w(plru_w), .plru_out(plru_out), .way_sel(way_sel),
        .dawmux_sel(dawmux_sel), .addr_sel(addr_sel), .arb_mem_read(arb_mem_read),
        .arb_mem_write(arb_mem_write), .mem_resp(mem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control_nway #(.WAYS(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
        .arb_mem_resp(arb_mem_resp),
        .valid_w(s_valid_w), .tag_w(s_tag_w), .data_w(s_data_w), .dirty_w(s_dirty_w),
        .dirty_in(s_dirty_in), .plru_w(s_plru_w), .plru_out(s_plru_out), .way_sel(s_way_sel),
        .dawmux_sel(s_dawmux_sel), .addr_sel(s_addr_sel), .arb_mem_read(s_arb_mem_read),
        .arb_mem_write(s_arb_mem_write), .mem_resp(s_mem_resp),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    typedef struct packed {
        logic [3:0] valid_w, tag_w, data_w, dirty_w;
        logic       dirty_in, plru_w;
        logic [2:0] plru_out;
        logic [1:0] way_sel;
        logic       dawmux_sel, addr_sel, arb_mem_read, arb_mem_write, mem_resp;
    } outs_t;

    typedef struct {
        logic       rd, wr;
        logic [3:0] hit, valid, dirty;
        logic [2:0] plru;
        logic       resp;
        outs_t      exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic outs_t mk(logic [3:0] vw, logic [3:0] tw, logic [3:0] dw, logic [3:0] dtw,
                                 logic din, logic pw, logic [2:0] po, logic [1:0] ws,
                                 logic dm, logic as, logic ar, logic aw, logic mr);
        outs_t o;
        o.valid_w = vw; o.tag_w = tw; o.data_w = dw; o.dirty_w = dtw;
        o.dirty_in = din; o.plru_w = pw; o.plru_out = po; o.way_sel = ws;
        o.dawmux_sel = dm; o.addr_sel = as; o.arb_mem_read = ar; o.arb_mem_write = aw;
        o.mem_resp = mr;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return mk(valid_w, tag_w, data_w, dirty_w, dirty_in, plru_w, plru_out, way_sel,
                  dawmux_sel, addr_sel, arb_mem_read, arb_mem_write, mem_resp);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic rd, logic wr, logic [3:0] h, logic [3:0] v,
                         logic [3:0] d, logic [2:0] p, logic rsp);
        rst = r; mem_read = rd; mem_write = wr; hit_vec = h; valid_vec = v;
        dirty_vec = d; plru_in = p; arb_mem_resp = rsp;
    endtask

    // Compare combinational outputs mid-cycle, then advance to just after the edge.
    task automatic cyc(string name, outs_t exp);
        @(negedge clk);
        chk(name, 64'(dut_outs()), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(string name, int eh, int em);
        chk({name, "_hit"}, 64'(hit_count), 64'(eh));
        chk({name, "_miss"}, 64'(miss_count), 64'(em));
    endtask

    // Reference tree PLRU expressed as interval halving over the 4 ways.
    function automatic int m_victim(logic [2:0] p, logic [3:0] v);
        int lo, size, node, half;
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        lo = 0; size = 4; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (p[node]) begin lo += half; node = 2 * node + 2; end
            else node = 2 * node + 1;
            size = half;
        end
        return lo;
    endfunction

    function automatic logic [2:0] m_touch(logic [2:0] p, int w);
        int lo, size, node, half;
        logic [2:0] q;
        q = p; lo = 0; size = 4; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (w >= lo + half) begin q[node] = 1'b0; lo += half; node = 2 * node + 2; end
            else begin q[node] = 1'b1; node = 2 * node + 1; end
            size = half;
        end
        return q;
    endfunction

    function automatic int m_lowest(logic [3:0] h);
        for (int i = 0; i < 4; i++) if (h[i]) return i;
        return 0;
    endfunction

    function automatic int sat(int n, int mx);
        return (n > mx) ? mx : n;
    endfunction

    vec_t  tbl[7];
    outs_t z, alloc2, alloc3, wb3;
    int    ph, mv, nh, nm, k;
    logic  pend_rd, pend_wr, r_rst, r_rsp;
    logic [3:0] r_h, r_v, r_d;
    logic [2:0] r_p;
    outs_t e;

    initial begin
        z      = '0;
        alloc2 = mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 0, 0, 3'b000, 2'd0, 1, 0, 1, 0, 0);
        alloc3 = mk(4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 0, 3'b000, 2'd0, 1, 0, 1, 0, 0);
        wb3    = mk(0, 0, 0, 0, 0, 0, 3'b000, 2'd3, 0, 1, 0, 1, 0);

        tbl[0] = '{1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0,
                   mk(0, 0, 0, 0, 0, 1, 3'b011, 2'd0, 0, 0, 0, 0, 1)};
        tbl[1] = '{1'b0, 1'b1, 4'b0100, 4'b1111, 4'b0000, 3'b000, 1'b0,
                   mk(0, 0, 4'b0100, 4'b0100, 1, 1, 3'b100, 2'd2, 0, 0, 0, 0, 1)};
        tbl[2] = '{1'b1, 1'b0, 4'b1000, 4'b1111, 4'b1111, 3'b111, 1'b0,
                   mk(0, 0, 0, 0, 0, 1, 3'b010, 2'd3, 0, 0, 0, 0, 1)};
        tbl[3] = '{1'b1, 1'b0, 4'b0010, 4'b0011, 4'b0000, 3'b000, 1'b1,
                   mk(0, 0, 0, 0, 0, 1, 3'b001, 2'd1, 0, 0, 0, 0, 1)};
        tbl[4] = '{1'b0, 1'b1, 4'b0110, 4'b1111, 4'b0000, 3'b110, 1'b0,
                   mk(0, 0, 4'b0010, 4'b0010, 1, 1, 3'b101, 2'd1, 0, 0, 0, 0, 1)};
        tbl[5] = '{1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 3'b111, 1'b1, z};
        tbl[6] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, z};

        // Reset: outputs low while held, counters clear.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        cyc("rst_outs", z);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("idle", z);
        cnt("reset_cnt", 0, 0);

        // Single-cycle TAG_COMP behaviour from the vector table.
        for (int i = 0; i < 7; i++) begin
            drive(0, tbl[i].rd, tbl[i].wr, tbl[i].hit, tbl[i].valid, tbl[i].dirty,
                  tbl[i].plru, tbl[i].resp);
            cyc($sformatf("vec%0d", i), tbl[i].exp);
        end
        cnt("table_cnt", 5, 0);

        // Clean miss to invalid way 2; victim must survive valid/plru changes.
        drive(0, 1, 0, 4'b0000, 4'b1011, 4'b0000, 3'b000, 0);
        cyc("a_miss", z);
        drive(0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0);
        cyc("a_alloc0", alloc2);
        cyc("a_alloc1", alloc2);
        drive(0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1);
        cyc("a_alloc2", alloc2);
        drive(0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0);
        cyc("a_update", mk(0, 0, 0, 0, 0, 1, 3'b100, 2'd0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b100, 0);
        cyc("a_hit", mk(0, 0, 0, 0, 0, 1, 3'b100, 2'd2, 0, 0, 0, 0, 1));
        cnt("a_cnt", 6, 1);

        // Dirty miss, all valid: PLRU victim way 3 written back first.
        drive(0, 0, 1, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0);
        cyc("b_miss", z);
        cyc("b_wb0", wb3);
        drive(0, 0, 1, 4'b0000, 4'b1111, 4'b1000, 3'b101, 1);
        cyc("b_wb1", wb3);
        cyc("b_alloc", alloc3);
        cyc("b_update", mk(0, 0, 0, 0, 0, 1, 3'b000, 2'd0, 0, 0, 0, 0, 0));
        drive(0, 0, 1, 4'b1000, 4'b1111, 4'b1000, 3'b000, 0);
        cyc("b_hit", mk(0, 0, 4'b1000, 4'b1000, 1, 1, 3'b000, 2'd3, 0, 0, 0, 0, 1));
        cnt("b_cnt", 7, 2);

        // Reset held two cycles in the middle of ALLOCATE.
        drive(0, 1, 0, 4'b0000, 4'b0111, 4'b0000, 3'b000, 0);
        cyc("c_miss", z);
        cyc("c_alloc", alloc3);
        drive(1, 1, 0, 4'b0000, 4'b0111, 4'b0000, 3'b000, 0);
        @(negedge clk);
        chk("c_rst0", 64'(dut_outs()), 64'(z));
        chk("c_rst0_hitcnt", 64'(hit_count), 64'(0));
        chk("c_rst0_misscnt", 64'(miss_count), 64'(0));
        @(posedge clk);
        #1;
        drive(1, 1, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1);
        cyc("c_rst1", z);
        drive(0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 3'b000, 1);
        cyc("c_post_idle", z);
        cnt("c_cnt0", 0, 0);
        drive(0, 1, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0);
        cyc("c_hit", mk(0, 0, 0, 0, 0, 1, 3'b011, 2'd0, 0, 0, 0, 0, 1));
        cnt("c_cnt1", 1, 0);

        // Saturation on the 4-bit counter instance.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 4'b0001 << (i % 4), 4'b1111, 4'b0000, 3'($urandom), 0);
            @(posedge clk);
            #1;
            if (i == 13) chk("sat_pre", 64'(s_hit_count), 64'(15));
        end
        chk("sat_hit", 64'(s_hit_count), 64'(15));
        chk("sat_wide", 64'(hit_count), 64'(21));
        chk("sat_miss", 64'(s_miss_count), 64'(0));

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        ph = 0; mv = 0; nh = 0; nm = 0; pend_rd = 0; pend_wr = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            if (ph == 0 && !pend_rd && !pend_wr) begin
                k = $urandom_range(0, 2);
                pend_rd = (k == 1);
                pend_wr = (k == 2);
            end
            k = $urandom_range(0, 99);
            if (ph != 0 || k >= 85) r_h = 4'($urandom);
            else if (k < 40) r_h = 4'b0000;
            else r_h = 4'b0001 << $urandom_range(0, 3);
            r_v = 4'($urandom);
            if ($urandom_range(0, 1) == 1) r_v = 4'b1111;
            r_d = 4'($urandom);
            r_p = 3'($urandom);
            r_rsp = ($urandom_range(0, 99) < 35);
            drive(r_rst, pend_rd, pend_wr, r_h, r_v, r_d, r_p, r_rsp);

            e = '0;
            if (!r_rst) begin
                case (ph)
                    0: if (pend_rd || pend_wr) begin
                        if (r_h != 4'b0000) begin
                            k = m_lowest(r_h);
                            e.mem_resp = 1; e.way_sel = 2'(k); e.plru_w = 1;
                            e.plru_out = m_touch(r_p, k);
                            if (pend_wr) begin
                                e.data_w = 4'b0001 << k; e.dirty_w = 4'b0001 << k; e.dirty_in = 1;
                            end
                        end
                    end
                    1: begin e.arb_mem_write = 1; e.way_sel = 2'(mv); e.addr_sel = 1; end
                    2: begin
                        e.arb_mem_read = 1; e.dawmux_sel = 1;
                        e.data_w = 4'b0001 << mv; e.tag_w = 4'b0001 << mv;
                        e.valid_w = 4'b0001 << mv; e.dirty_w = 4'b0001 << mv;
                    end
                    default: begin e.plru_w = 1; e.plru_out = m_touch(r_p, mv); end
                endcase
            end
            cyc($sformatf("rnd%0d", c), e);

            if (r_rst) begin
                ph = 0; mv = 0; nh = 0; nm = 0;
            end else begin
                case (ph)
                    0: if (pend_rd || pend_wr) begin
                        if (r_h != 4'b0000) begin
                            nh++; pend_rd = 0; pend_wr = 0;
                        end else begin
                            nm++;
                            mv = m_victim(r_p, r_v);
                            ph = (r_v[mv] && r_d[mv]) ? 1 : 2;
                        end
                    end
                    1: if (r_rsp) ph = 2;
                    2: if (r_rsp) ph = 3;
                    default: ph = 0;
                endcase
            end
            if (!r_rst) begin
                chk("rnd_hitcnt", 64'(hit_count), 64'(sat(nh, 65535)));
                chk("rnd_misscnt", 64'(miss_count), 64'(sat(nm, 65535)));
                chk("rnd_s_hitcnt", 64'(s_hit_count), 64'(sat(nh, 15)));
                chk("rnd_s_misscnt", 64'(s_miss_count), 64'(sat(nm, 15)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
